// File: rtl/vdc_frame_capture.sv
// vdc_frame_capture
//   Video sink for the epochtv1 VDC. Samples DE/HS/VS/RGB on the pixel clock
//   enable, measures per-frame timing, folds every active pixel into a 32-bit
//   rotate-xor signature, and publishes the results on each VS leading edge.
//
// Ports
//   CLK        in   system clock
//   RESB       in   synchronous active-low reset
//   CE         in   pixel clock enable (inputs sampled only when CE=1)
//   DE         in   active-video enable
//   HS         in   horizontal sync (active level HS_POL)
//   VS         in   vertical sync (active level VS_POL)
//   RGB        in   {R,G,B} pixel, valid when DE=1
//   FRAME_DONE out  one-CLK strobe, result outputs change in this cycle
//   ACT_W      out  active pixels on the first active line of the frame
//   ACT_H      out  active lines in the frame
//   HTOTAL     out  CE cycles between the last two HS leading edges
//   VTOTAL     out  HS leading edges in the frame
//   SIG        out  pixel signature of the frame
//   FRAME_CNT  out  frames published since reset (wraps)
//   WIDTH_ERR  out  some active line differed in length from ACT_W
module vdc_frame_capture #(
    parameter int   CW     = 12,
    parameter logic HS_POL = 1'b0,
    parameter logic VS_POL = 1'b0
) (
    input  logic          CLK,
    input  logic          RESB,
    input  logic          CE,
    input  logic          DE,
    input  logic          HS,
    input  logic          VS,
    input  logic [23:0]   RGB,
    output logic          FRAME_DONE,
    output logic [CW-1:0] ACT_W,
    output logic [CW-1:0] ACT_H,
    output logic [CW-1:0] HTOTAL,
    output logic [CW-1:0] VTOTAL,
    output logic [31:0]   SIG,
    output logic [15:0]   FRAME_CNT,
    output logic          WIDTH_ERR
);

    localparam logic [CW-1:0] C_ONE = {{(CW-1){1'b0}}, 1'b1};

    typedef enum logic {S_SYNC, S_RUN} state_t;

    state_t r_state;
    state_t w_state_nxt;

    // Previous-sample registers (raw input levels)
    logic r_de_prev;
    logic r_hs_prev;
    logic r_vs_prev;

    // Per-frame accumulators
    logic [31:0]   r_sig;
    logic [CW-1:0] r_pix;
    logic [CW-1:0] r_wref;
    logic [CW-1:0] r_h;
    logic [CW-1:0] r_ht;
    logic [CW-1:0] r_v;
    logic          r_err;
    logic          r_first;
    logic [CW-1:0] r_hcnt;

    // Accumulator values including the current sample
    logic [31:0]   w_sig_nxt;
    logic [CW-1:0] w_pix_nxt;
    logic [CW-1:0] w_wref_nxt;
    logic [CW-1:0] w_h_nxt;
    logic [CW-1:0] w_ht_nxt;
    logic [CW-1:0] w_v_nxt;
    logic          w_err_nxt;
    logic          w_first_nxt;

    logic w_hs_lead;
    logic w_vs_lead;
    logic w_de_fall;
    logic w_frame_start;
    logic w_publish;
    logic w_accum;

    function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] x);
        return (&x) ? x : x + C_ONE;
    endfunction

    assign w_hs_lead = (HS == HS_POL) && (r_hs_prev != HS_POL);
    assign w_vs_lead = (VS == VS_POL) && (r_vs_prev != VS_POL);
    assign w_de_fall = r_de_prev && !DE;

    // FSM: state register
    always_ff @(posedge CLK) begin
        if (!RESB) begin
            r_state <= S_SYNC;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // FSM: next state
    always_comb begin
        w_state_nxt = r_state;
        if (CE && w_vs_lead && (r_state == S_SYNC)) begin
            w_state_nxt = S_RUN;
        end
    end

    // FSM: outputs. The first VS edge out of SYNC only opens a frame.
    always_comb begin
        w_frame_start = 1'b0;
        w_publish     = 1'b0;
        w_accum       = 1'b0;
        if (CE) begin
            w_frame_start = w_vs_lead;
            w_publish     = w_vs_lead && (r_state == S_RUN);
            w_accum       = (r_state == S_RUN);
        end
    end

    // Accumulator update for the current sample. Publishing uses these
    // values so that a DE fall or HS edge coinciding with the VS edge is
    // counted into the closing frame.
    always_comb begin
        w_sig_nxt   = r_sig;
        w_pix_nxt   = r_pix;
        w_wref_nxt  = r_wref;
        w_h_nxt     = r_h;
        w_ht_nxt    = r_ht;
        w_v_nxt     = r_v;
        w_err_nxt   = r_err;
        w_first_nxt = r_first;

        if (DE) begin
            w_sig_nxt = {r_sig[30:0], r_sig[31]} ^ {8'h00, RGB};
            w_pix_nxt = sat_inc(r_pix);
        end

        if (w_de_fall) begin
            if (r_first) begin
                w_wref_nxt = r_pix;
            end else if (r_pix != r_wref) begin
                w_err_nxt = 1'b1;
            end
            w_h_nxt     = sat_inc(r_h);
            w_pix_nxt   = '0;
            w_first_nxt = 1'b0;
        end

        if (w_hs_lead) begin
            w_ht_nxt = r_hcnt;
            w_v_nxt  = sat_inc(r_v);
        end
    end

    always_ff @(posedge CLK) begin
        if (!RESB) begin
            r_de_prev  <= 1'b0;
            r_hs_prev  <= ~HS_POL;
            r_vs_prev  <= ~VS_POL;
            r_sig      <= '0;
            r_pix      <= '0;
            r_wref     <= '0;
            r_h        <= '0;
            r_ht       <= '0;
            r_v        <= '0;
            r_err      <= 1'b0;
            r_first    <= 1'b1;
            r_hcnt     <= '0;
            FRAME_DONE <= 1'b0;
            ACT_W      <= '0;
            ACT_H      <= '0;
            HTOTAL     <= '0;
            VTOTAL     <= '0;
            SIG        <= '0;
            FRAME_CNT  <= '0;
            WIDTH_ERR  <= 1'b0;
        end else begin
            FRAME_DONE <= w_publish;

            // The line-period counter runs in every state so HTOTAL is
            // already meaningful for the first published frame.
            if (CE) begin
                r_de_prev <= DE;
                r_hs_prev <= HS;
                r_vs_prev <= VS;
                r_hcnt    <= w_hs_lead ? C_ONE : sat_inc(r_hcnt);
            end

            if (w_frame_start) begin
                r_sig   <= '0;
                r_pix   <= '0;
                r_wref  <= '0;
                r_h     <= '0;
                r_ht    <= '0;
                r_v     <= '0;
                r_err   <= 1'b0;
                r_first <= 1'b1;
            end else if (w_accum) begin
                r_sig   <= w_sig_nxt;
                r_pix   <= w_pix_nxt;
                r_wref  <= w_wref_nxt;
                r_h     <= w_h_nxt;
                r_ht    <= w_ht_nxt;
                r_v     <= w_v_nxt;
                r_err   <= w_err_nxt;
                r_first <= w_first_nxt;
            end

            if (w_publish) begin
                ACT_W     <= w_wref_nxt;
                ACT_H     <= w_h_nxt;
                HTOTAL    <= w_ht_nxt;
                VTOTAL    <= w_v_nxt;
                SIG       <= w_sig_nxt;
                WIDTH_ERR <= w_err_nxt;
                FRAME_CNT <= FRAME_CNT + 16'd1;
            end
        end
    end

endmodule

// File: doc/vdc_frame_capture.md
Name: vdc_frame_capture

Overview:
- Downstream video sink for the epochtv1 VDC. It consumes DE/HS/VS/RGB on the VDC pixel clock-enable.
- Each frame it measures timing (active width/height, horizontal total, vertical total) and folds every active pixel into a 32-bit signature.
- At each frame boundary it publishes the results with a one-cycle strobe.
- Sits beside the VDC+VRAM bench wrapper so benches and on-board self-test compare frames by signature instead of dumping pixels.

Parameters:
- CW, 12, width of all pixel/line counters.
- HS_POL, 1'b0, active level of HS (0 = active-low).
- VS_POL, 1'b0, active level of VS (0 = active-low).

Ports:
- CLK  in  1  system clock
- RESB  in  1  synchronous active-low reset
- CE  in  1  pixel clock enable; inputs are sampled only when CE=1
- DE  in  1  active-video enable from VDC
- HS  in  1  horizontal sync from VDC
- VS  in  1  vertical sync from VDC
- RGB  in  24  pixel {R,G,B} from VDC, valid when DE=1
- FRAME_DONE  out  1  one-CLK strobe; result outputs updated this cycle
- ACT_W  out  CW  active pixels per line (first active line of frame)
- ACT_H  out  CW  active lines in frame
- HTOTAL  out  CW  CE-cycles between HS leading edges (last full line)
- VTOTAL  out  CW  HS leading edges between VS leading edges
- SIG  out  32  pixel signature of the frame
- FRAME_CNT  out  16  frames published since reset, wraps 0xFFFF->0
- WIDTH_ERR  out  1  some active line in the published frame differed from ACT_W

Behaviour:
- Reset (RESB=0 at CLK edge): all outputs 0, accumulators 0, previous-sample registers hold the inactive level (DE=0, HS=~HS_POL, VS=~VS_POL), state=SYNC.
- Sampling: all logic below advances only on CLK edges with CE=1. With CE=0, state and accumulators hold, and FRAME_DONE is 0.
- Edges: a leading edge is "prev inactive & current active". A DE fall is prev DE=1 & current DE=0.
- States:
  - SYNC: discard everything until the first VS leading edge, then clear accumulators and go to RUN. No FRAME_DONE is produced on this edge.
  - RUN: accumulate. On a VS leading edge, publish, pulse FRAME_DONE, clear accumulators, stay in RUN.
- Signature: when DE=1, sig_acc <= {sig_acc[30:0], sig_acc[31]} ^ {8'h00, RGB}. Cleared to 0 at frame start.
- Width:
  - Pixel count increments while DE=1.
  - On a DE fall: if it is the first line of the frame, capture w_ref. Otherwise, if the count != w_ref, set the sticky width-error flag. Then increment h_acc and clear the pixel count.
- HTOTAL: a line counter increments every CE cycle and restarts at 1 on the cycle an HS leading edge is sampled. On that edge, the previous count is held as ht_acc.
- VTOTAL: v_acc increments on each HS leading edge.
- Same-cycle events:
  - A DE fall and a VS leading edge in one sample: the line is counted into the frame being published.
  - An HS edge and a VS edge in one sample: the HS is counted into the closing frame; the new frame's v_acc starts at 0.
- Publish (registered): ACT_W=w_ref, ACT_H=h_acc, HTOTAL=ht_acc, VTOTAL=v_acc, SIG=sig_acc including the current pixel, WIDTH_ERR=sticky flag, FRAME_CNT+1. FRAME_DONE=1 in the same CLK cycle the outputs change.
- Saturation: all CW counters saturate at all-ones. SIG and FRAME_CNT wrap.
- Empty frame (no DE): ACT_W=0, ACT_H=0, SIG=0, WIDTH_ERR=0.
- Reset mid-frame: returns to SYNC; the partial frame is never published.
- Latency: FRAME_DONE rises at the CLK edge where the VS leading edge is sampled with CE=1.

Test Plan:
- Synthetic 8 px x 4 lines, HTOTAL 12, 6 lines/frame, VS/HS active-low, CE every cycle, RGB=0x000001 constant -> the first VS edge gives no strobe; the second gives FRAME_DONE=1 for exactly one cycle, ACT_W=8, ACT_H=4, HTOTAL=12, VTOTAL=6, FRAME_CNT=1, WIDTH_ERR=0, and SIG equal to the bench model's value (rotate-xor of 32 pixels of 0x000001).
- Same stream with CE asserted every 2nd cycle -> identical ACT_W/ACT_H/HTOTAL/VTOTAL/SIG.
- Line 3 shortened to 7 px -> WIDTH_ERR=1 for that frame, ACT_W=8. The next clean frame gives WIDTH_ERR=0.
- Frame with DE held low -> ACT_W=0, ACT_H=0, SIG=0, VTOTAL=6.
- RESB pulsed low mid-frame -> outputs return to 0 and no FRAME_DONE at the next VS. The frame after it publishes with FRAME_CNT=1.
- Real epochtv1 via the VDC+VRAM bench, VRAM filled with 0x00 -> two consecutive frames give an equal nonzero ACT_W/ACT_H and an identical SIG.
